// File: rtl/stopwatch_if.sv
// stopwatch_if: button/mode inputs and digit/strobe outputs between timebase and display driver
interface stopwatch_if;
  logic        pause_btn;
  logic        clr_btn;
  logic        adj;
  logic        adj_sel;
  logic [17:0] out7seg;
  logic [25:0] outadj;
  logic [4:0]  min_l;
  logic [4:0]  min_r;
  logic [4:0]  sec_l;
  logic [4:0]  sec_r;
  logic        running;
  modport master (
    output pause_btn, clr_btn, adj, adj_sel,
    input  out7seg, outadj, min_l, min_r, sec_l, sec_r, running
  );
  modport slave (
    input  pause_btn, clr_btn, adj, adj_sel,
    output out7seg, outadj, min_l, min_r, sec_l, sec_r, running
  );
endinterface

// File: rtl/stopwatch_timebase.sv
// stopwatch_timebase: mm:ss BCD stopwatch with button conditioning and scan/adjust strobe counters
module stopwatch_timebase #(
  parameter int SEC_DIV  = 100000000,
  parameter int ADJ_DIV  = 50000000,
  parameter int SCAN_DIV = 262144
) (
  input logic clk,
  input logic rst,
  stopwatch_if.slave bus
);
  localparam int SW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  logic [2:0]    r_ps, r_cs;
  logic          r_pause_p, r_clr_p, r_running;
  logic [SW-1:0] r_sec_cnt;
  logic [17:0]   r_scan;
  logic [25:0]   r_adj;
  logic [3:0]    r_min_l, r_min_r, r_sec_l, r_sec_r;
  logic          w_adj_tick, w_sec_tick, w_sr_wrap, w_sl_wrap, w_mr_wrap, w_ml_wrap, w_inc_s, w_inc_m;
  assign w_adj_tick = r_adj == 26'(ADJ_DIV - 1);
  assign w_sec_tick = r_running && !bus.adj && r_sec_cnt == SW'(SEC_DIV - 1);
  assign w_sr_wrap  = r_sec_r == 4'd9;
  assign w_sl_wrap  = r_sec_l == 4'd5;
  assign w_mr_wrap  = r_min_r == 4'd9;
  assign w_ml_wrap  = r_min_l == 4'd5;
  // adjust ticks hit one field only, so seconds never carry into minutes while adjusting
  assign w_inc_s = w_sec_tick || (w_adj_tick && bus.adj && !bus.adj_sel);
  assign w_inc_m = (w_sec_tick && w_sr_wrap && w_sl_wrap) || (w_adj_tick && bus.adj && bus.adj_sel);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ps      <= '0;
      r_cs      <= '0;
      r_pause_p <= 1'b0;
      r_clr_p   <= 1'b0;
      r_running <= 1'b0;
      r_sec_cnt <= '0;
      r_scan    <= '0;
      r_adj     <= '0;
      r_min_l   <= '0;
      r_min_r   <= '0;
      r_sec_l   <= '0;
      r_sec_r   <= '0;
    end else begin
      r_ps      <= {r_ps[1:0], bus.pause_btn};
      r_cs      <= {r_cs[1:0], bus.clr_btn};
      r_pause_p <= r_ps[1] && !r_ps[2];
      r_clr_p   <= r_cs[1] && !r_cs[2];
      r_running <= !r_clr_p && (r_running ^ r_pause_p);
      r_sec_cnt <= (r_clr_p || !r_running || bus.adj || w_sec_tick) ? '0 : r_sec_cnt + 1'b1;
      r_scan    <= (r_scan == 18'(SCAN_DIV - 1)) ? '0 : r_scan + 1'b1;
      r_adj     <= w_adj_tick ? '0 : r_adj + 1'b1;
      r_sec_r   <= r_clr_p ? '0 : w_inc_s ? (w_sr_wrap ? '0 : r_sec_r + 1'b1) : r_sec_r;
      r_sec_l   <= r_clr_p ? '0 : (w_inc_s && w_sr_wrap) ? (w_sl_wrap ? '0 : r_sec_l + 1'b1) : r_sec_l;
      r_min_r   <= r_clr_p ? '0 : w_inc_m ? (w_mr_wrap ? '0 : r_min_r + 1'b1) : r_min_r;
      r_min_l   <= r_clr_p ? '0 : (w_inc_m && w_mr_wrap) ? (w_ml_wrap ? '0 : r_min_l + 1'b1) : r_min_l;
    end
  end
  assign bus.out7seg = r_scan;
  assign bus.outadj  = r_adj;
  assign bus.min_l   = {1'b0, r_min_l};
  assign bus.min_r   = {1'b0, r_min_r};
  assign bus.sec_l   = {1'b0, r_sec_l};
  assign bus.sec_r   = {1'b0, r_sec_r};
  assign bus.running = r_running;
endmodule

// File: tb/tb_stopwatch_timebase.sv
// tb_stopwatch_timebase: directed stimulus checked every cycle against a seconds-based model
module tb_stopwatch_timebase;
  localparam int SEC_DIV  = 10;
  localparam int ADJ_DIV  = 4;
  localparam int SCAN_DIV = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  stopwatch_if sw();
  stopwatch_timebase #(.SEC_DIV(SEC_DIV), .ADJ_DIV(ADJ_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(sw)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  int m_t, m_scan, m_adj, m_cnt;
  bit m_run, m_pp, m_cp, m_at;
  bit [4:0] m_ps, m_cs;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int dmin();
    return int'(sw.min_l) * 10 + int'(sw.min_r);
  endfunction
  function automatic int dsec();
    return int'(sw.sec_l) * 10 + int'(sw.sec_r);
  endfunction
  function automatic int dall();
    return dmin() * 100 + dsec();
  endfunction
  task automatic wait_dut(input string name, input int mm, input int ss, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = (dmin() == mm) && (dsec() == ss);
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL %s: timeout, display %0d expected %0d", name, dall(), mm * 100 + ss);
    end
  endtask
  // model: elapsed time as plain seconds; a button edge acts 3 samples after it is first seen
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_t = 0; m_scan = 0; m_adj = 0; m_cnt = 0; m_run = 0; m_ps = 0; m_cs = 0;
      end else begin
        m_ps = {m_ps[3:0], sw.pause_btn};
        m_cs = {m_cs[3:0], sw.clr_btn};
        m_pp = m_ps[3] && !m_ps[4];
        m_cp = m_cs[3] && !m_cs[4];
        m_at = (m_adj == ADJ_DIV - 1);
        m_scan = (m_scan + 1) % SCAN_DIV;
        m_adj = (m_adj + 1) % ADJ_DIV;
        if (m_cp) begin
          m_t = 0; m_run = 0; m_cnt = 0;
        end else begin
          if (m_run && !sw.adj) begin
            if (m_cnt == SEC_DIV - 1) begin
              m_cnt = 0;
              m_t = (m_t + 1) % 3600;
            end else m_cnt++;
          end else m_cnt = 0;
          if (sw.adj && m_at)
            m_t = sw.adj_sel ? ((m_t / 60 + 1) % 60) * 60 + m_t % 60 : (m_t / 60) * 60 + (m_t % 60 + 1) % 60;
          if (m_pp) m_run = !m_run;
        end
      end
    end
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("out7seg", int'(sw.out7seg), m_scan);
      chk("outadj", int'(sw.outadj), m_adj);
      chk("min_l", int'(sw.min_l), m_t / 600);
      chk("min_r", int'(sw.min_r), (m_t / 60) % 10);
      chk("sec_l", int'(sw.sec_l), (m_t % 60) / 10);
      chk("sec_r", int'(sw.sec_r), m_t % 10);
      chk("running", int'(sw.running), int'(m_run));
    end
  end
  initial begin
    sw.pause_btn = 0; sw.clr_btn = 0; sw.adj = 0; sw.adj_sel = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("reset_running", int'(sw.running), 0);
    chk("reset_digits", dall(), 0);
    repeat (50) @(posedge clk);
    @(negedge clk); sw.pause_btn = 1;
    repeat (3) @(posedge clk); #1;
    chk("pause_edge3", int'(sw.running), 0);
    @(posedge clk); #1;
    chk("pause_edge4", int'(sw.running), 1);
    @(posedge clk);
    @(negedge clk); sw.pause_btn = 0;
    repeat (9) @(posedge clk); #1;
    chk("first_second", int'(sw.sec_r), 1);
    chk("pin_model_1s", m_t, 1);
    repeat (90) @(posedge clk); #1;
    chk("ten_seconds", dsec(), 10);
    chk("pin_model_10s", m_t, 10);
    chk("single_toggle", int'(sw.running), 1);
    @(negedge clk); sw.clr_btn = 1;
    repeat (2) @(negedge clk); sw.clr_btn = 0;
    repeat (6) @(posedge clk); #1;
    chk("clr_digits", dall(), 0);
    chk("clr_running", int'(sw.running), 0);
    @(negedge clk); sw.adj = 1; sw.adj_sel = 1;
    wait_dut("preload_min", 59, 0, 59 * 4 + 10);
    @(negedge clk); sw.adj_sel = 0;
    wait_dut("preload_sec", 59, 58, 58 * 4 + 10);
    @(negedge clk); sw.adj = 0; sw.pause_btn = 1;
    repeat (2) @(negedge clk); sw.pause_btn = 0;
    wait_dut("run_5959", 59, 59, 30);
    wait_dut("wrap_0000", 0, 0, SEC_DIV);
    chk("wrap_running", int'(sw.running), 1);
    chk("pin_model_wrap", m_t, 0);
    @(negedge clk); sw.adj = 1; sw.adj_sel = 0;
    wait_dut("adj_sec58", 0, 58, 58 * 4 + 10);
    repeat (4) @(posedge clk); #1;
    chk("adj_sec59", dall(), 59);
    repeat (4) @(posedge clk); #1;
    chk("adj_sec_wrap", dsec(), 0);
    chk("adj_no_carry", int'(sw.min_r), 0);
    @(negedge clk); sw.adj_sel = 1;
    wait_dut("adj_min59", 59, 0, 60 * 4 + 10);
    repeat (4) @(posedge clk); #1;
    chk("adj_min_wrap", dall(), 0);
    wait_dut("adj_min12", 12, 0, 12 * 4 + 10);
    @(negedge clk); sw.adj_sel = 0;
    wait_dut("adj_sec34", 12, 34, 34 * 4 + 10);
    @(negedge clk); sw.adj = 0; sw.clr_btn = 1;
    repeat (3) @(posedge clk); #1;
    chk("clr_e3_running", int'(sw.running), 1);
    chk("clr_e3_digits", dall(), 1234);
    @(posedge clk); #1;
    chk("clr_e4_running", int'(sw.running), 0);
    chk("clr_e4_digits", dall(), 0);
    @(negedge clk); sw.clr_btn = 0;
    repeat (3) @(negedge clk); sw.pause_btn = 1; sw.clr_btn = 1;
    repeat (4) @(posedge clk); #1;
    chk("both_running", int'(sw.running), 0);
    chk("both_digits", dall(), 0);
    @(negedge clk); sw.pause_btn = 0; sw.clr_btn = 0;
    repeat (20) @(posedge clk); #1;
    chk("both_stays_paused", int'(sw.running), 0);
    @(negedge clk); sw.adj = 1; sw.adj_sel = 1;
    wait_dut("adj_min03", 3, 0, 3 * 4 + 10);
    @(negedge clk); sw.adj_sel = 0;
    wait_dut("adj_sec07", 3, 7, 7 * 4 + 10);
    @(negedge clk); sw.adj = 0; sw.pause_btn = 1;
    repeat (4) @(posedge clk); #1;
    chk("pre_rst_running", int'(sw.running), 1);
    chk("pre_rst_digits", dall(), 307);
    @(negedge clk); sw.pause_btn = 0;
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_digits", dall(), 0);
    chk("async_rst_running", int'(sw.running), 0);
    chk("async_rst_scan", int'(sw.out7seg), 0);
    chk("async_rst_adj", int'(sw.outadj), 0);
    @(negedge clk); rst = 0;
    repeat (30) @(posedge clk); #1;
    chk("post_rst_idle_run", int'(sw.running), 0);
    chk("post_rst_idle_digits", dall(), 0);
    @(negedge clk); sw.pause_btn = 1;
    repeat (2) @(negedge clk); sw.pause_btn = 0;
    repeat (30) @(posedge clk); #1;
    chk("post_rst_count", dall(), 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
